// File: rtl/relu_ctrl_pkg.sv
// Shared defaults and helpers for the shared-ReLU arbiter.
// Imported by the arbiter top and its result buffer.
package relu_ctrl_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_RELU_LAT   = 3;
  localparam int DEF_FIFO_DEPTH = 4;

  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/relu_res_fifo.sv
// Synchronous result buffer with a registered occupancy count.
// Payload is {id, data}; outputs read as zero while empty.
module relu_res_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push,
  input  logic [W-1:0]           i_data,
  input  logic                   i_pop,
  output logic                   o_valid,
  output logic [W-1:0]           o_data,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign o_valid = (r_count != '0);
  assign w_pop   = i_pop && o_valid;
  assign o_data  = o_valid ? r_mem[r_rd] : '0;
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/relu_share_arb.sv
// Round-robin sharing of one pipelined ReLU unit between requesters.
// Credits cover buffered plus in-flight results so the buffer never overflows.
module relu_share_arb
  import relu_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int RELU_LAT   = DEF_RELU_LAT,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         relu_z,
  input  logic [DATA_WIDTH-1:0]         relu_a,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic [id_width(NUM_REQ)-1:0]  res_id,
  output logic                          busy
);

  localparam int IW = id_width(NUM_REQ);
  localparam int PW = DATA_WIDTH + IW;
  localparam int CW = $clog2(FIFO_DEPTH + RELU_LAT + 1);

  logic [IW-1:0]              r_ptr;
  logic [RELU_LAT-1:0]        r_tag_v;
  logic [IW-1:0]              r_tag_id [RELU_LAT];
  logic [CW-1:0]              r_inflight;

  logic                       w_found;
  logic [IW-1:0]              w_win_id;
  logic                       w_credit;
  logic                       w_issue;
  logic                       w_push;
  logic                       w_fifo_valid;
  logic [PW-1:0]              w_fifo_data;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_cnt;
  logic [CW-1:0]              w_occ;
  int                         v_idx;

  always_comb begin
    w_found  = 1'b0;
    w_win_id = '0;
    v_idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      v_idx = int'(r_ptr) + k;
      if (v_idx >= NUM_REQ) v_idx = v_idx - NUM_REQ;
      if (!w_found && req_valid[v_idx]) begin
        w_found  = 1'b1;
        w_win_id = IW'(v_idx);
      end
    end
  end

  // Registered occupancy only: a same-cycle pop frees its credit next cycle.
  assign w_occ     = CW'(w_fifo_cnt) + r_inflight;
  assign w_credit  = (w_occ < CW'(FIFO_DEPTH));
  assign w_issue   = !rst && w_found && w_credit;
  assign req_ready = w_issue ? (NUM_REQ'(1) << w_win_id) : '0;
  assign relu_z    = w_issue ?
                     req_data[w_win_id*DATA_WIDTH +: DATA_WIDTH] : '0;

  assign w_push = r_tag_v[RELU_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr <= '0;
    end else if (w_issue) begin
      r_ptr <= (w_win_id == IW'(NUM_REQ-1)) ? '0 : w_win_id + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v <= '0;
      for (int i = 0; i < RELU_LAT; i++) r_tag_id[i] <= '0;
    end else begin
      r_tag_v[0]  <= w_issue;
      r_tag_id[0] <= w_win_id;
      for (int i = 1; i < RELU_LAT; i++) begin
        r_tag_v[i]  <= r_tag_v[i-1];
        r_tag_id[i] <= r_tag_id[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inflight <= '0;
    end else begin
      unique case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  relu_res_fifo #(
    .W     (PW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  ({r_tag_id[RELU_LAT-1], relu_a}),
    .i_pop   (res_valid && res_ready),
    .o_valid (w_fifo_valid),
    .o_data  (w_fifo_data),
    .o_count (w_fifo_cnt)
  );

  assign res_valid = !rst && w_fifo_valid;
  assign res_data  = rst ? '0 : w_fifo_data[DATA_WIDTH-1:0];
  assign res_id    = rst ? '0 : w_fifo_data[PW-1:DATA_WIDTH];
  assign busy      = !rst &&
                     ((r_inflight != '0) || (w_fifo_cnt != '0));

endmodule
